acc_unit: RTL and testbench
===========================

ACC_UNIT -- requirements
Module: acc_unit

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have: op_valid  input  1  operation request.
REQ-004 SHALL have: op_ready  output  1  unit can accept an operation this cycle.
REQ-005 SHALL have: op  input  3  opcode: 000 NOP, 001 ADD, 010 SUB, 011 MUL, 100 NOT, 101 MOV, 110/111 reserved, treated as NOP.
REQ-006 SHALL have: arg  input  11  signed operand.
REQ-007 SHALL have: acc  output  11  signed accumulator, always within -999..999.
REQ-008 SHALL have: done  output  1  one-cycle pulse after the operation's result is written to acc.
REQ-009 SHALL have: busy  output  1  high while a multi-cycle MUL is in progress.

Function
REQ-010 SHALL accept an operation on a rising edge where op_valid and op_ready are both high; op and arg are sampled only on that edge.
REQ-011 SHALL clamp arg to -999..999 before use; -1024 becomes -999 and 1023 becomes 999.
REQ-012 SHALL compute ADD and SUB through an instance of the existing saturating adder (add: acc, arg1, out), with SUB feeding the negated clamped arg.
REQ-013 SHALL write ADD, SUB, NOT, MOV and NOP results on the accepting edge and raise done during the following cycle only.
REQ-014 SHALL implement NOT as acc := 100 when acc == 0, else acc := 0.
REQ-015 SHALL implement MOV as acc := clamped arg; NOP/reserved leave acc unchanged but still pulse done.
REQ-016 SHALL keep op_ready high in IDLE, including the cycle done is high, so back-to-back single-cycle ops complete one per clock.
REQ-017 SHALL use FSM states IDLE, MUL, DONE: IDLE→MUL on an accepted MUL; MUL→DONE after 10 iteration edges; DONE→IDLE unconditionally on the next edge.
REQ-018 SHALL perform MUL as 10-step shift-add of the 10-bit magnitudes into a 20-bit unsigned product, then apply sign = sign(acc) XOR sign(arg), then saturate to ±999.
REQ-019 SHALL write the MUL result to acc on the MUL→DONE edge (10 edges after acceptance) and assert done during DONE.
REQ-020 SHALL hold op_ready low and busy high in MUL and DONE; acc holds its pre-MUL value until the result is written.
REQ-021 SHALL produce +0 for any MUL with a zero operand, never -0.
REQ-022 SHALL ignore op_valid while op_ready is low; no request is queued.

Reset
REQ-023 SHALL on rst, at any state including mid-MUL, set acc=0, done=0, busy=0, op_ready=1 and state IDLE, discarding any partial product, with no done pulse.
REQ-024 SHALL give rst priority over a simultaneous accepted operation; that operation is dropped.

Configuration
REQ-025 SHALL compile the iterative multiplier and the MUL/DONE states only when ACC_UNIT_MUL_EN is defined.
REQ-026 SHALL, without ACC_UNIT_MUL_EN, treat opcode 011 as NOP (single cycle, acc unchanged, done pulsed, busy constantly 0).

Verification
REQ-027 SHALL cover: reset, MOV arg=-51, ADD arg=-51 -> acc=-102, done one cycle after each accept.
REQ-028 SHALL cover: acc=900, ADD 900 -> 999; then SUB -1024 -> 999 (clamp plus saturation).
REQ-029 SHALL cover: acc=-25, MUL arg=27 -> acc=-675 exactly 10 edges after accept, busy high 11 cycles, op_ready low throughout.
REQ-030 SHALL cover: acc=500, MUL -3 -> -999; acc=0, MUL -7 -> 0; then NOT -> 100, NOT -> 0.
REQ-031 SHALL cover: rst asserted 5 cycles into MUL -> acc=0, no done, next MOV 7 accepted immediately.
REQ-032 SHALL cover: ACC_UNIT_MUL_EN undefined, acc=12, MUL 3 -> acc=12, done next cycle, busy never high.

Source files
------------

// File: rtl/acc_unit.sv
// Saturating accumulator (range -999..999) with single-cycle ADD/SUB/NOT/MOV/NOP.
// Define ACC_UNIT_MUL_EN to build the iterative 10-step MUL and its MUL/DONE states.

module add (
  input  logic signed [10:0] acc,
  input  logic signed [10:0] arg1,
  output logic signed [10:0] out
);
  logic signed [11:0] a_s;
  logic signed [11:0] b_s;
  logic signed [11:0] sum_s;

  // widen by one bit, add, and saturate the sum to +/-999
  always_comb begin
    a_s   = {acc[10], acc};
    b_s   = {arg1[10], arg1};
    sum_s = a_s + b_s;
    if (sum_s > 12'sd999) begin
      out = 11'sd999;
    end else if (sum_s < -12'sd999) begin
      out = -11'sd999;
    end else begin
      out = sum_s[10:0];
    end
  end
endmodule

module acc_unit (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [2:0]         op,
  input  logic signed [10:0] arg,
  output logic signed [10:0] acc,
  output logic               done,
  output logic               busy
);
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;

`ifdef ACC_UNIT_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b011;
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [0:0] {IDLE = 1'b0} state_t;
`endif

  state_t             state_r;
  state_t             state_nx_s;
  logic signed [10:0] acc_r;
  logic signed [10:0] acc_nx_s;
  logic signed [10:0] argc_s;
  logic signed [10:0] arg1_s;
  logic signed [10:0] add_out_s;
  logic               done_r;
  logic               done_nx_s;
  logic               busy_r;
  logic               op_ready_r;
  logic               accept_s;

  function automatic logic signed [10:0] clamp999(input logic signed [10:0] v);
    if (v > 11'sd999) begin
      clamp999 = 11'sd999;
    end else if (v < -11'sd999) begin
      clamp999 = -11'sd999;
    end else begin
      clamp999 = v;
    end
  endfunction

  add u_add (
    .acc  (acc_r),
    .arg1 (arg1_s),
    .out  (add_out_s)
  );

  // operand conditioning: clamp, then negate for SUB
  always_comb begin
    accept_s = op_valid && op_ready_r;
    argc_s   = clamp999(arg);
    if (op == OP_SUB) begin
      arg1_s = -argc_s;
    end else begin
      arg1_s = argc_s;
    end
  end

`ifdef ACC_UNIT_MUL_EN
  logic [19:0]        mcand_r;
  logic [9:0]         mplier_r;
  logic [19:0]        prod_r;
  logic [19:0]        prod_nx_s;
  logic [3:0]         cnt_r;
  logic               neg_r;
  logic [9:0]         mag_s;
  logic signed [10:0] mul_res_s;
  logic               mul_start_s;

  function automatic logic [9:0] mag10(input logic signed [10:0] v);
    if (v[10]) begin
      mag10 = 10'(-v);
    end else begin
      mag10 = v[9:0];
    end
  endfunction

  // one shift-add step and the signed, saturated result it would produce
  always_comb begin
    if (mplier_r[0]) begin
      prod_nx_s = prod_r + mcand_r;
    end else begin
      prod_nx_s = prod_r;
    end
    if (prod_nx_s > 20'd999) begin
      mag_s = 10'd999;
    end else begin
      mag_s = prod_nx_s[9:0];
    end
    // two's complement has no -0, so a zero magnitude always yields +0
    if (neg_r) begin
      mul_res_s = -$signed({1'b0, mag_s});
    end else begin
      mul_res_s = $signed({1'b0, mag_s});
    end
  end

  // multiplier datapath: load magnitudes on accept, then shift-add per edge
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r  <= 20'd0;
      mplier_r <= 10'd0;
      prod_r   <= 20'd0;
      cnt_r    <= 4'd0;
      neg_r    <= 1'b0;
    end else if (mul_start_s) begin
      mcand_r  <= {10'd0, mag10(argc_s)};
      mplier_r <= mag10(acc_r);
      prod_r   <= 20'd0;
      cnt_r    <= 4'd0;
      neg_r    <= acc_r[10] ^ argc_s[10];
    end else if (state_r == MUL) begin
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      prod_r   <= prod_nx_s;
      cnt_r    <= cnt_r + 4'd1;
    end else begin
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
      prod_r   <= prod_r;
      cnt_r    <= cnt_r;
      neg_r    <= neg_r;
    end
  end
`endif

  // next-state and result selection
  always_comb begin
    state_nx_s = state_r;
    acc_nx_s   = acc_r;
    done_nx_s  = 1'b0;
`ifdef ACC_UNIT_MUL_EN
    mul_start_s = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          done_nx_s = 1'b1;
          case (op)
            OP_ADD, OP_SUB: acc_nx_s = add_out_s;
            OP_NOT: begin
              if (acc_r == 11'sd0) begin
                acc_nx_s = 11'sd100;
              end else begin
                acc_nx_s = 11'sd0;
              end
            end
            OP_MOV: acc_nx_s = argc_s;
`ifdef ACC_UNIT_MUL_EN
            OP_MUL: begin
              done_nx_s   = 1'b0;
              mul_start_s = 1'b1;
              state_nx_s  = MUL;
            end
`endif
            default: acc_nx_s = acc_r;
          endcase
        end else begin
          state_nx_s = IDLE;
        end
      end
`ifdef ACC_UNIT_MUL_EN
      MUL: begin
        if (cnt_r == 4'd9) begin
          state_nx_s = DONE;
          acc_nx_s   = mul_res_s;
          done_nx_s  = 1'b1;
        end else begin
          state_nx_s = MUL;
        end
      end
      DONE: state_nx_s = IDLE;
`endif
      default: state_nx_s = IDLE;
    endcase
  end

  // state and registered outputs; reset wins over any accepted operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      acc_r      <= 11'sd0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      op_ready_r <= 1'b1;
    end else begin
      state_r    <= state_nx_s;
      acc_r      <= acc_nx_s;
      done_r     <= done_nx_s;
      busy_r     <= (state_nx_s != IDLE);
      op_ready_r <= (state_nx_s == IDLE);
    end
  end

  assign acc      = acc_r;
  assign done     = done_r;
  assign busy     = busy_r;
  assign op_ready = op_ready_r;
endmodule

// File: tb/tb_acc_unit.sv
// Self-checking bench for acc_unit: vector table for single-cycle ops, hand sequences
// for MUL and reset corners, and a done-driven scoreboard of expected acc values.
module tb_acc_unit;
  logic               clk;
  logic               rst;
  logic               op_valid;
  logic               op_ready;
  logic [2:0]         op;
  logic signed [10:0] arg;
  logic signed [10:0] acc;
  logic               done;
  logic               busy;

  int n_vec;
  int n_err;
  int busy_seen;
  logic signed [10:0] exp_q[$];

  typedef struct {
    logic [2:0]         op;
    logic signed [10:0] arg;
    logic signed [10:0] exp;
  } vec_t;
  vec_t vecs[$];

  acc_unit dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op       (op),
    .arg      (arg),
    .acc      (acc),
    .done     (done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (busy) busy_seen++;
    if (done) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_spurious_done: got done with acc %0d, expected no done", acc);
      end else begin
        logic signed [10:0] e;
        e = exp_q.pop_front();
        if (acc !== e) begin
          n_err++;
          $display("FAIL sb_acc: got %0d expected %0d", acc, e);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic signed [10:0] a,
                       input logic signed [10:0] e, input string nm);
    op_valid = 1'b1;
    op       = o;
    arg      = a;
    exp_q.push_back(e);
    step();
    chk({nm, " acc"}, acc, e);
    chk({nm, " done"}, done, 1);
    chk({nm, " ready"}, op_ready, 1);
  endtask

`ifdef ACC_UNIT_MUL_EN
  task automatic mul_op(input logic signed [10:0] a, input logic signed [10:0] pre,
                        input logic signed [10:0] e, input string nm);
    int bad;
    bad      = 0;
    op_valid = 1'b1;
    op       = 3'b011;
    arg      = a;
    exp_q.push_back(e);
    step();
    op  = 3'b101;
    arg = 11'sd5;
    for (int k = 1; k <= 10; k++) begin
      if (!(busy && !op_ready && !done && acc == pre)) bad++;
      step();
    end
    chk({nm, " hold"}, bad, 0);
    chk({nm, " acc"}, acc, e);
    chk({nm, " done/busy/ready"}, {done, busy, op_ready}, 3'b110);
    op_valid = 1'b0;
    step();
    chk({nm, " idle done/busy/ready"}, {done, busy, op_ready}, 3'b001);
    chk({nm, " acc kept"}, acc, e);
  endtask
`endif

  initial begin
    n_vec     = 0;
    n_err     = 0;
    busy_seen = 0;
    rst       = 1'b1;
    op_valid  = 1'b0;
    op        = 3'b000;
    arg       = 11'sd0;

    vecs.push_back('{op: 3'b101, arg: -11'sd51,   exp: -11'sd51});
    vecs.push_back('{op: 3'b001, arg: -11'sd51,   exp: -11'sd102});
    vecs.push_back('{op: 3'b101, arg: 11'sd900,   exp: 11'sd900});
    vecs.push_back('{op: 3'b001, arg: 11'sd900,   exp: 11'sd999});
    vecs.push_back('{op: 3'b010, arg: -11'sd1024, exp: 11'sd999});
    vecs.push_back('{op: 3'b101, arg: 11'sd1023,  exp: 11'sd999});
    vecs.push_back('{op: 3'b101, arg: -11'sd1024, exp: -11'sd999});
    vecs.push_back('{op: 3'b010, arg: 11'sd5,     exp: -11'sd999});
    vecs.push_back('{op: 3'b001, arg: 11'sd1000,  exp: 11'sd0});
    vecs.push_back('{op: 3'b100, arg: 11'sd3,     exp: 11'sd100});
    vecs.push_back('{op: 3'b100, arg: 11'sd0,     exp: 11'sd0});
    vecs.push_back('{op: 3'b000, arg: 11'sd77,    exp: 11'sd0});
    vecs.push_back('{op: 3'b101, arg: 11'sd12,    exp: 11'sd12});
`ifndef ACC_UNIT_MUL_EN
    vecs.push_back('{op: 3'b011, arg: 11'sd3,     exp: 11'sd12});
`endif
    vecs.push_back('{op: 3'b110, arg: 11'sd44,    exp: 11'sd12});
    vecs.push_back('{op: 3'b111, arg: -11'sd44,   exp: 11'sd12});
    vecs.push_back('{op: 3'b010, arg: -11'sd20,   exp: 11'sd32});
    vecs.push_back('{op: 3'b100, arg: 11'sd0,     exp: 11'sd0});

    step();
    step();
    chk("reset acc", acc, 0);
    chk("reset done/busy/ready", {done, busy, op_ready}, 3'b001);
    rst = 1'b0;

    // back-to-back single-cycle operations, op_valid held high throughout
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].op, vecs[i].arg, vecs[i].exp, $sformatf("vec%0d", i));
    end
    op_valid = 1'b0;
    step();
    chk("idle no done", done, 0);

`ifdef ACC_UNIT_MUL_EN
    issue(3'b101, -11'sd25, -11'sd25, "mov -25");
    mul_op(11'sd27, -11'sd25, -11'sd675, "mul 27");
    issue(3'b101, 11'sd500, 11'sd500, "mov 500");
    mul_op(-11'sd3, 11'sd500, -11'sd999, "mul -3");
    issue(3'b101, 11'sd0, 11'sd0, "mov 0");
    mul_op(-11'sd7, 11'sd0, 11'sd0, "mul -7");
    issue(3'b100, 11'sd0, 11'sd100, "not a");
    issue(3'b100, 11'sd0, 11'sd0, "not b");
    issue(3'b101, -11'sd999, -11'sd999, "mov -999");
    mul_op(-11'sd1024, -11'sd999, 11'sd999, "mul -1024");
    issue(3'b101, -11'sd13, -11'sd13, "mov -13");
    mul_op(11'sd0, -11'sd13, 11'sd0, "mul 0");

    // reset five cycles into a MUL: partial product dropped, no done pulse
    issue(3'b101, 11'sd7, 11'sd7, "mov 7 pre");
    op  = 3'b011;
    arg = 11'sd9;
    step();
    op_valid = 1'b0;
    repeat (4) step();
    chk("mid-mul busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid-mul rst acc", acc, 0);
    chk("mid-mul rst done/busy/ready", {done, busy, op_ready}, 3'b001);
    issue(3'b101, 11'sd7, 11'sd7, "mov 7 post");
    op_valid = 1'b0;
    step();
`else
    chk("busy never high", busy_seen, 0);
`endif

    // reset beats a simultaneous accepted operation
    issue(3'b101, 11'sd7, 11'sd7, "mov 7 idle");
    rst = 1'b1;
    op  = 3'b101;
    arg = 11'sd33;
    step();
    rst      = 1'b0;
    op_valid = 1'b0;
    chk("rst vs op acc", acc, 0);
    chk("rst vs op done", done, 0);
    step();
    chk("rst vs op late done", done, 0);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
